// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic valid/ready pipeline register with optional 2-entry skid and flush bubble
module pipe_stage_skid #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_FIELDS = 4,
    parameter bit                SKID       = 1'b1,
    parameter int                NOP_FIELD  = 3,
    parameter logic [DATA_W-1:0] NOP_VALUE  = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    output logic [1:0]                   occupancy
);

    localparam int PW = NUM_FIELDS * DATA_W;

    function automatic logic [PW-1:0] bubble_f();
        logic [PW-1:0] b;
        b = '0;
        b[NOP_FIELD*DATA_W +: DATA_W] = NOP_VALUE;
        return b;
    endfunction

    localparam logic [PW-1:0] BUBBLE = bubble_f();

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    if (SKID) begin : g_skid
        state_t          state_q, state_d;
        logic [PW-1:0]   main_q, main_d;
        logic [PW-1:0]   skid_q, skid_d;
        logic            in_ready_q, in_ready_d;
        logic            in_fire, out_fire;

        assign in_fire  = in_valid && in_ready_q;
        assign out_fire = (state_q != EMPTY) && out_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Reset and flush share one path so a mid-run reset looks exactly like a flush.
            if (rst || flush) begin
                state_d = EMPTY;
                main_d  = BUBBLE;
                skid_d  = BUBBLE;
            end
            in_ready_d = (state_d != FULL);
        end

        always_ff @(posedge clk) begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end

        assign in_ready  = in_ready_q;
        assign out_valid = (state_q != EMPTY);
        assign out_data  = main_q;
        assign occupancy = state_q;
    end else begin : g_noskid
        logic          valid_q, valid_d;
        logic [PW-1:0] main_q, main_d;
        logic          in_fire, out_fire;

        assign in_ready = !valid_q || out_ready;
        assign in_fire  = in_valid && in_ready;
        assign out_fire = valid_q && out_ready;

        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (in_fire) begin
                valid_d = 1'b1;
                main_d  = in_data;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
            if (rst || flush) begin
                valid_d = 1'b0;
                main_d  = BUBBLE;
            end
        end

        always_ff @(posedge clk) begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end

        assign out_valid = valid_q;
        assign out_data  = main_q;
        assign occupancy = {1'b0, valid_q};
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed vectors for SKID=1 and scoreboard run for SKID=0
module tb_pipe_stage_skid;

    localparam logic [127:0] BUB = {32'h0000_0013, 96'h0};

    logic         clk = 1'b0;
    logic         rst;
    logic         flush1, in_valid1, out_ready1;
    logic [127:0] in_data1;
    logic         in_ready1, out_valid1;
    logic [127:0] out_data1;
    logic [1:0]   occ1;
    logic         flush0, in_valid0, out_ready0;
    logic [127:0] in_data0;
    logic         in_ready0, out_valid0;
    logic [127:0] out_data0;
    logic [1:0]   occ0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.SKID(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occ1)
    );

    pipe_stage_skid #(.SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occ0)
    );

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [31:0] d0;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [1:0]  eocc;
        logic [31:0] ef0;
    } vec_t;

    vec_t vecs[$];

    // Payload field3 is derived from field0 so the whole word is exercised; 0 means bubble.
    function automatic logic [127:0] pay(input logic [31:0] f0);
        return (f0 == 32'h0) ? BUB : {f0 | 32'h0000_0A00, 64'h0, f0};
    endfunction

    task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d0,
                       input logic ordy, input logic eov, input logic eir,
                       input logic [1:0] eocc, input logic [31:0] ef0);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d0 = d0; v.ordy = ordy;
        v.eov = eov; v.eir = eir; v.eocc = eocc; v.ef0 = ef0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    logic [127:0] sb[$];
    logic [127:0] exp_front;
    int           seq;
    logic         m_valid, iv, ordy, exp_ir;

    initial begin
        rst = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst1_out_valid", 0, out_valid1, 1'b0);
        chk("rst1_in_ready", 0, in_ready1, 1'b1);
        chk("rst1_occ", 0, occ1, 2'd0);
        chk("rst1_data", 0, out_data1, BUB);
        chk("rst0_out_valid", 0, out_valid0, 1'b0);
        chk("rst0_data", 0, out_data0, BUB);

        // rst, flush, in_valid, d0, out_ready | out_valid, in_ready, occ, field0
        for (int k = 1; k <= 8; k++) add(0, 0, 1, k, 1, 1, 1, 1, k);
        add(0, 0, 0, 0,     1, 0, 1, 0, 8);
        add(0, 0, 1, 32'hA, 0, 1, 1, 1, 32'hA);
        add(0, 0, 1, 32'hB, 0, 1, 0, 2, 32'hA);
        add(0, 0, 1, 32'hC, 0, 1, 0, 2, 32'hA);
        add(0, 0, 0, 0,     1, 1, 1, 1, 32'hB);
        add(0, 0, 0, 0,     1, 0, 1, 0, 32'hB);
        add(0, 0, 1, 32'h1A, 0, 1, 1, 1, 32'h1A);
        add(0, 0, 1, 32'h1B, 0, 1, 0, 2, 32'h1A);
        add(0, 1, 1, 32'h1C, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0,     1, 0, 1, 0, 0);
        add(0, 1, 1, 32'h5, 1, 0, 1, 0, 0);
        add(0, 0, 1, 32'h21, 0, 1, 1, 1, 32'h21);
        add(0, 1, 1, 32'h22, 1, 0, 1, 0, 0);
        add(0, 0, 1, 32'h31, 0, 1, 1, 1, 32'h31);
        add(0, 0, 1, 32'h32, 1, 1, 1, 1, 32'h32);
        add(0, 0, 0, 0,     1, 0, 1, 0, 32'h32);
        add(0, 0, 1, 32'h41, 0, 1, 1, 1, 32'h41);
        add(0, 0, 1, 32'h42, 0, 1, 0, 2, 32'h41);
        add(1, 0, 1, 32'h43, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0,     1, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            rst        = vecs[i].r;
            flush1     = vecs[i].f;
            in_valid1  = vecs[i].iv;
            in_data1   = pay(vecs[i].d0);
            out_ready1 = vecs[i].ordy;
            @(posedge clk);
            @(negedge clk);
            chk("out_valid", i, out_valid1, vecs[i].eov);
            chk("in_ready", i, in_ready1, vecs[i].eir);
            chk("occupancy", i, occ1, vecs[i].eocc);
            chk("out_data", i, out_data1, pay(vecs[i].ef0));
        end
        rst = 1'b0; flush1 = 1'b0; in_valid1 = 1'b0;

        m_valid = 1'b0;
        seq = 1;
        for (int c = 0; c < 2000; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            in_valid0  = iv;
            out_ready0 = ordy;
            in_data0   = {~seq[31:0], 64'h0, seq[31:0]};
            #1;
            exp_ir = !m_valid || ordy;
            chk("s0_in_ready", c, in_ready0, exp_ir);
            chk("s0_out_valid", c, out_valid0, m_valid);
            chk("s0_occ", c, occ0, {1'b0, m_valid});
            if (m_valid) begin
                exp_front = sb[0];
                chk("s0_out_data", c, out_data0, exp_front);
                if (ordy) void'(sb.pop_front());
            end
            if (iv && exp_ir) begin
                sb.push_back({~seq[31:0], 64'h0, seq[31:0]});
                seq++;
            end
            m_valid = (sb.size() != 0);
            @(posedge clk);
            @(negedge clk);
        end

        flush0 = 1'b1; in_valid0 = 1'b1; out_ready0 = 1'b0; in_data0 = pay(32'h55);
        @(posedge clk);
        @(negedge clk);
        flush0 = 1'b0; in_valid0 = 1'b0;
        chk("s0_flush_valid", 0, out_valid0, 1'b0);
        chk("s0_flush_occ", 0, occ0, 2'd0);
        chk("s0_flush_data", 0, out_data0, BUB);
        chk("s0_flush_in_ready", 0, in_ready0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, elastic pipeline-stage register that generalises the fixed EX/MEM latch. It carries NUM_FIELDS payload words of DATA_W bits between two pipeline stages using valid/ready flow control, with optional 2-entry skid buffering and a synchronous flush that injects a bubble. Every inter-stage boundary of the core instantiates it: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 32, width of one payload field.
NUM_FIELDS, 4, number of payload fields; total payload width is NUM_FIELDS*DATA_W.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
NOP_FIELD, 3, index of the field that takes NOP_VALUE on reset or flush; all other fields take 0.
NOP_VALUE, 32'h0000_0013, bubble encoding for field NOP_FIELD (the addi x0,x0,0 NOP).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  synchronous kill of all stage contents.
in_valid  in  1  upstream has a payload.
in_ready  out  1  stage can accept a payload this cycle.
in_data  in  NUM_FIELDS*DATA_W  payload; field k is in_data[k*DATA_W +: DATA_W].
out_valid  out  1  out_data holds a valid payload.
out_ready  in  1  downstream accepts the payload this cycle.
out_data  out  NUM_FIELDS*DATA_W  payload presented downstream.
occupancy  out  2  number of held entries: 0, 1 or 2.

Behaviour:
- Handshake rules:
  - Input fire = in_valid && in_ready. Output fire = out_valid && out_ready.
  - Payloads leave in arrival order, with no loss and no duplication.
  - out_valid and out_data stay stable while out_valid && !out_ready.
- Latency: a payload accepted at edge N appears on out_data with out_valid=1 after edge N, giving 1-cycle latency when the stage is empty.
- Reset and flush values:
  - out_valid=0, occupancy=0, in_ready=1.
  - out_data = bubble: field NOP_FIELD = NOP_VALUE, all other fields 0.
  - The skid register is cleared to the same bubble value.
- SKID=1 state machine:
  - States are EMPTY, ONE and FULL. A main register drives out_data; a skid register holds the overflow entry.
  - in_ready = (state != FULL). It is a registered signal and has no combinational path from out_ready.
  - EMPTY: input fire -> ONE, main<=in_data.
  - ONE, input fire with output fire -> ONE, main<=in_data.
  - ONE, input fire only -> FULL, skid<=in_data.
  - ONE, output fire only -> EMPTY. out_data holds its last value; only out_valid is meaningful.
  - FULL: no input is possible. Output fire -> ONE, main<=skid.
  - occupancy is 0/1/2 for EMPTY/ONE/FULL.
- SKID=0:
  - Single register. in_ready = !out_valid || out_ready (combinational).
  - Input fire loads main and sets out_valid=1.
  - Output fire without input fire clears out_valid.
  - Simultaneous input and output fire gives pass-through replacement, with out_valid staying 1.
  - occupancy is limited to 0 or 1.
- Priority: rst, then flush, then the normal handshake.
  - When flush=1, any payload offered or handshaking that cycle is discarded.
  - The state after the edge equals the reset state, including the bubble on out_data.
  - An output fire in the flush cycle still counts as consumed downstream.
- Reset mid-operation behaves identically to flush. Inputs are ignored while rst=1.
- No arithmetic. Widths are fixed by the parameters, with no truncation or extension of fields.

Test Plan:
- Reset then idle: rst high for 2 cycles, then low with in_valid=0. Required: out_valid=0, in_ready=1, occupancy=0, out_data field3=32'h13, fields 0..2 = 0.
- Streaming: out_ready=1 and in_valid=1 for 8 cycles, in_data field0 = 1..8. Required: out_data field0 = 1..8 one cycle later, one per cycle, occupancy stays 1.
- Backpressure (SKID=1): send A and B while out_ready=0. Required: occupancy=2 and in_ready=0 after B; A held stable on out_data. Release out_ready: A, then B on consecutive cycles, and in_ready=1 the cycle after A leaves.
- Flush while FULL: flush=1 with A and B held and C offered. Required: next cycle out_valid=0, occupancy=0, bubble on out_data; A, B and C never appear on the output.
- Flush simultaneous with input fire in EMPTY: in_valid=1 with in_data field0=5 and flush=1. Required: out_valid stays 0 and field0=0.
- SKID=0 random: random in_valid/out_ready for 2000 cycles against a scoreboard. Required: in-order data, no loss or duplication, in_ready == !out_valid || out_ready on every cycle.
